xor_mask_pipe: RTL
==================

Name: xor_mask_pipe

Overview:
- Parametrised, pipelined successor to the team's XOR/AND-mask composition primitive.
- Computes r = ((a ^ b) & MASK) ^ (b & MASK) on WIDTH-bit operands through a 2-stage valid/ready pipeline.
- Mode 0 passes r through. Mode 1 folds r into a running XOR accumulator with frame delimiting.
- Sits between a streaming operand source and a checksum/compare consumer. Sustains one result per cycle.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
MASK, {WIDTH{1'b1}}, constant bit mask applied in stage 1
CNT_W, 8, width of the delivered-result counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
in_a  input  WIDTH  operand a
in_b  input  WIDTH  operand b
in_mode  input  1  0 = pass, 1 = accumulate (sampled per beat)
in_last  input  1  last beat of accumulate frame (ignored when in_mode=0)
acc_clear  input  1  synchronous accumulator clear
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  pass result or accumulator value
out_last  output  1  registered copy of beat's in_last & in_mode
out_count  output  CNT_W  number of delivered results, wraps

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low. On assertion all state clears immediately, regardless of clk:
  - stage valids = 0, accumulator = 0, out_count = 0
  - out_valid = 0, out_data = 0, out_last = 0
  - in_ready = 1 once stage 1 is empty, i.e. in_ready = 1 during reset
- Release is synchronous to the next clk edge.
- Stage 1 register holds: s1_x = (a^b)&MASK, s1_y = b&MASK, mode, last.
- Stage 2 is the output register: out_data, out_last, out_valid.
- adv2 = s1_valid & (~out_valid | out_ready).
- in_ready = ~s1_valid | adv2. This is combinational from out_ready; no comb path from in_valid.
- Input transfer: in_valid & in_ready at a clk edge. A beat with in_valid and in_ready low is held by the source; the block captures nothing.
- Latency: beat accepted at edge k gives out_valid high after edge k+1 when unstalled. Throughput is 1 beat/cycle.
- Stall: while out_valid & ~out_ready, out_data/out_last stay stable. Stage 1 holds its beat. At most 2 beats are buffered; in_ready drops when both stages are full.
- Stage-2 load, on adv2, with r = s1_x ^ s1_y:
  - Pass mode: out_data = r. Accumulator is untouched.
  - Accumulate mode: acc_n = acc ^ r; out_data = acc_n.
  - Accumulator update: acc <= acc_n, or 0 if s1_last (frame end; the next frame starts from 0).
- acc_clear: acc <= 0 at the edge. If acc_clear coincides with an accumulate load, the loaded beat uses acc = 0, so out_data = r. The post-load accumulator is also 0 if that beat is last; otherwise it is r.
- acc_clear does not affect in-flight pass beats or out_data already in stage 2.
- Mode may change beat to beat. Each beat carries its own mode through stage 1.
- out_count: increments by 1 on out_valid & out_ready and wraps modulo 2^CNT_W.
- Ordering: results leave in acceptance order, with no loss or duplication under any in_valid/out_ready pattern.
- Reset mid-frame discards buffered beats and the partial accumulator. No stale out_valid after release.

Test Plan:
- Pass: WIDTH=8, MASK=8'h0F, out_ready=1; beat a=8'hA5, b=8'h3C, mode 0 -> out_data=8'h05 (=a&MASK) one cycle after acceptance; out_count=1.
- Accumulate frame: MASK=8'hFF; beats a=01, 02, 04 with b=00, mode 1, last on the third -> out_data 01, 03, 07 with out_last only on 07. Next frame beat a=10 -> out_data 10.
- Backpressure: out_ready=0, offer 3 pass beats a=11, 22, 33 (b=0, MASK=FF) -> 2 accepted and in_ready=0. Raise out_ready -> outputs 11, 22, 33 in order; out_count=3.
- Clear collision: accumulator=0F, acc_clear asserted on the same edge as an accumulate beat a=F0 (not last) -> out_data=F0, accumulator=F0.
- Counter wrap: CNT_W=4, 17 delivered results -> out_count=1.
- Reset mid-operation: assert rst_n=0 between clk edges with both stages full -> out_valid=0, out_count=0 immediately. After release, a mode-1 beat a=05 -> out_data=05.

Source files
------------

// File: rtl/xor_mask_pipe.sv
// xor_mask_pipe
//   Two-stage valid/ready pipeline computing r = ((a ^ b) & MASK) ^ (b & MASK).
//   Stage 1 registers the masked partial terms. Stage 2 is the output register.
//   Each beat carries its own mode:
//     mode 0 : the beat passes r straight through.
//     mode 1 : r is folded into a running XOR accumulator, and the new
//              accumulator value is delivered. A beat with last set ends the
//              frame, so the next frame starts from zero.
//   The pipeline sustains one beat per cycle and buffers at most two beats.
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   in_valid/ready   operand beat handshake (in_ready depends on out_ready only)
//   in_a, in_b       operands (WIDTH bits)
//   in_mode          0 = pass, 1 = accumulate
//   in_last          end of accumulate frame (meaningful only when in_mode = 1)
//   acc_clear        synchronous accumulator clear
//   out_valid/ready  result handshake
//   out_data         pass result or accumulator value
//   out_last         registered in_last & in_mode of the delivered beat
//   out_count        delivered-result counter, wraps modulo 2^CNT_W
module xor_mask_pipe #(
  parameter int unsigned            WIDTH = 8,
  parameter logic [WIDTH-1:0]       MASK  = {WIDTH{1'b1}},
  parameter int unsigned            CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  input  logic             in_last,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] out_count
);

  // Stage 1 state
  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic             s1_mode;
  logic             s1_last;

  // Accumulator state
  logic [WIDTH-1:0] acc;

  // Handshake terms
  logic adv2;     // stage 1 moves into stage 2 this cycle
  logic accept;   // input beat captured into stage 1 this cycle

  // Stage-2 load values
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] load_data;

  assign adv2     = s1_valid & (~out_valid | out_ready);
  // Stage 1 frees up in the same cycle it advances, so a full pipe still
  // streams at one beat per cycle. There is no path from in_valid to in_ready.
  assign in_ready = ~s1_valid | adv2;
  assign accept   = in_valid & in_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    r         = s1_x ^ s1_y;
    // A clear on the same edge as an accumulate load makes that beat see a
    // zero accumulator.
    acc_base  = acc_clear ? '0 : acc;
    acc_n     = acc_base ^ r;
    load_data = s1_mode ? acc_n : r;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_mode  <= 1'b0;
      s1_last  <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_x     <= (in_a ^ in_b) & MASK;
      s1_y     <= in_b & MASK;
      s1_mode  <= in_mode;
      s1_last  <= in_last & in_mode;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (adv2) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_last  <= s1_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (adv2 && s1_mode) begin
      acc <= s1_last ? '0 : acc_n;
    end else if (acc_clear) begin
      acc <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
    end else if (out_valid && out_ready) begin
      out_count <= out_count + CNT_W'(1);
    end
  end

endmodule
